// File: rtl/regs_pkg.sv
// Shared register-file dimensions for the processor core.
package regs_pkg;
  localparam int REGS_DATA_W = 64;
  localparam int REGS_ADDR_W = 5;
  localparam int REGS_NUM    = 2 ** REGS_ADDR_W;
endpackage

// File: rtl/regs_rdport.sv
// One registered read port: loads the selected word when enabled, else holds.
module regs_rdport
  import regs_pkg::*;
#(
  parameter int DATA_W = REGS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [0:DATA_W-1] data_in,
  output logic [0:DATA_W-1] data_out
);

  logic [0:DATA_W-1] data_d;
  logic [0:DATA_W-1] data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: rtl/regs.sv
// Two-read / two-write register file, big-endian bit numbering, registered reads.
module regs
  import regs_pkg::*;
#(
  parameter int DATA_W = REGS_DATA_W,
  parameter int ADDR_W = REGS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readEn0,
  input  logic [0:ADDR_W-1] readAddr0,
  output logic [0:DATA_W-1] readData0,
  input  logic              readEn1,
  input  logic [0:ADDR_W-1] readAddr1,
  output logic [0:DATA_W-1] readData1,
  input  logic              writeEn0,
  input  logic [0:ADDR_W-1] writeAddr0,
  input  logic [0:DATA_W-1] writeData0,
  input  logic              writeEn1,
  input  logic [0:ADDR_W-1] writeAddr1,
  input  logic [0:DATA_W-1] writeData1
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [0:DATA_W-1] regs_d [NUM_REGS];
  logic [0:DATA_W-1] regs_q [NUM_REGS];

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (writeEn0) regs_d[writeAddr0] = writeData0;
    if (writeEn1) regs_d[writeAddr1] = writeData1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Read ports sample the pre-write contents, so same-edge reads see old data.
  regs_rdport #(.DATA_W(DATA_W)) u_rd0 (
    .clk      (clk),
    .reset    (reset),
    .en       (readEn0),
    .data_in  (regs_q[readAddr0]),
    .data_out (readData0)
  );

  regs_rdport #(.DATA_W(DATA_W)) u_rd1 (
    .clk      (clk),
    .reset    (reset),
    .en       (readEn1),
    .data_in  (regs_q[readAddr1]),
    .data_out (readData1)
  );

endmodule

// File: tb/tb_regs.sv
// Directed, table-driven bench for the regs register file.
module tb_regs;

  logic        clk;
  logic        reset;
  logic        readEn0, readEn1, writeEn0, writeEn1;
  logic [0:4]  readAddr0, readAddr1, writeAddr0, writeAddr1;
  logic [0:63] readData0, readData1, writeData0, writeData1;

  int n_chk  = 0;
  int n_pass = 0;

  regs dut (
    .clk        (clk),
    .reset      (reset),
    .readEn0    (readEn0),
    .readAddr0  (readAddr0),
    .readData0  (readData0),
    .readEn1    (readEn1),
    .readAddr1  (readAddr1),
    .readData1  (readData1),
    .writeEn0   (writeEn0),
    .writeAddr0 (writeAddr0),
    .writeData0 (writeData0),
    .writeEn1   (writeEn1),
    .writeAddr1 (writeAddr1),
    .writeData1 (writeData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [0:4]  wa0;
    logic [0:63] wd0;
    logic        we1;
    logic [0:4]  wa1;
    logic [0:63] wd1;
    logic        re0;
    logic [0:4]  ra0;
    logic        re1;
    logic [0:4]  ra1;
    logic [0:63] exp0;
    logic [0:63] exp1;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [0:63] act, input logic [0:63] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    writeEn0 = 0; writeAddr0 = 0; writeData0 = '0;
    writeEn1 = 0; writeAddr1 = 0; writeData1 = '0;
    readEn0  = 0; readAddr0  = 0;
    readEn1  = 0; readAddr1  = 0;
  endtask

  initial begin
    //           we0 wa0 wd0                     we1 wa1 wd1                     re0 ra0 re1 ra1  exp0                    exp1
    vecs[0]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 1,  1, 1,  64'h0,                  64'h0};
    vecs[1]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 0,  1, 31, 64'h0,                  64'h0};
    vecs[2]  = '{1, 5,  64'h0123456789ABCDEF,   0, 0,  64'h0,                  0, 0,  1, 5,  64'h0,                  64'h0};
    vecs[3]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 5,  1, 5,  64'h0123456789ABCDEF,   64'h0123456789ABCDEF};
    vecs[4]  = '{1, 7,  64'h1111,               1, 7,  64'h2222,               0, 0,  0, 0,  64'h0123456789ABCDEF,   64'h0123456789ABCDEF};
    vecs[5]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 7,  1, 0,  64'h2222,               64'h0};
    vecs[6]  = '{1, 3,  64'h55,                 1, 4,  64'h66,                 0, 0,  0, 0,  64'h2222,               64'h0};
    vecs[7]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 3,  1, 4,  64'h55,                 64'h66};
    vecs[8]  = '{1, 3,  64'hAA,                 0, 0,  64'h0,                  1, 3,  1, 3,  64'h55,                 64'h55};
    vecs[9]  = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 3,  0, 3,  64'hAA,                 64'h55};
    vecs[10] = '{1, 0,  64'hDEADBEEFCAFEF00D,   1, 31, 64'hFFFFFFFFFFFFFFFF,   0, 0,  0, 0,  64'hAA,                 64'h55};
    vecs[11] = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 0,  1, 31, 64'hDEADBEEFCAFEF00D,   64'hFFFFFFFFFFFFFFFF};
    vecs[12] = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 5,  0, 0,  64'h0123456789ABCDEF,   64'hFFFFFFFFFFFFFFFF};
    vecs[13] = '{0, 0,  64'h0,                  1, 5,  64'h99,                 0, 5,  0, 0,  64'h0123456789ABCDEF,   64'hFFFFFFFFFFFFFFFF};
    vecs[14] = '{0, 0,  64'h0,                  0, 0,  64'h0,                  0, 5,  0, 5,  64'h0123456789ABCDEF,   64'hFFFFFFFFFFFFFFFF};
    vecs[15] = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 5,  1, 5,  64'h99,                 64'h99};
    vecs[16] = '{0, 7,  64'hBAD,                0, 3,  64'hBAD,                0, 0,  0, 0,  64'h99,                 64'h99};
    vecs[17] = '{0, 0,  64'h0,                  0, 0,  64'h0,                  1, 7,  1, 3,  64'h2222,               64'hAA};

    // Reset held across two edges with a write and reads presented.
    idle();
    reset = 1;
    writeEn0 = 1; writeAddr0 = 1; writeData0 = 64'h5;
    readEn0 = 1; readAddr0 = 1; readEn1 = 1; readAddr1 = 1;
    #12;
    check("reset_rd0", readData0, 64'h0);
    check("reset_rd1", readData1, 64'h0);
    @(negedge clk);
    reset = 0;
    idle();

    for (int i = 0; i < NVEC; i++) begin
      writeEn0 = vecs[i].we0; writeAddr0 = vecs[i].wa0; writeData0 = vecs[i].wd0;
      writeEn1 = vecs[i].we1; writeAddr1 = vecs[i].wa1; writeData1 = vecs[i].wd1;
      readEn0  = vecs[i].re0; readAddr0  = vecs[i].ra0;
      readEn1  = vecs[i].re1; readAddr1  = vecs[i].ra1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rd0", i), readData0, vecs[i].exp0);
      check($sformatf("vec%0d_rd1", i), readData1, vecs[i].exp1);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle after r10 has been written and read back.
    idle();
    writeEn0 = 1; writeAddr0 = 10; writeData0 = 64'hFF;
    @(negedge clk);
    idle();
    readEn0 = 1; readAddr0 = 10; readEn1 = 1; readAddr1 = 10;
    @(posedge clk);
    #1;
    check("r10_rd0", readData0, 64'hFF);
    check("r10_rd1", readData1, 64'hFF);
    #2;
    reset = 1;
    #1;
    check("async_rst_rd0", readData0, 64'h0);
    check("async_rst_rd1", readData1, 64'h0);
    writeEn0 = 1; writeAddr0 = 10; writeData0 = 64'h77;
    @(posedge clk);
    #1;
    check("rst_hold_rd0", readData0, 64'h0);
    @(negedge clk);
    reset = 0;
    idle();
    readEn0 = 1; readAddr0 = 10; readEn1 = 1; readAddr1 = 7;
    @(posedge clk);
    #1;
    check("post_rst_r10", readData0, 64'h0);
    check("post_rst_r7", readData1, 64'h0);
    @(negedge clk);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
